// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART receiver types, frame constants and helpers
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } rx_state_e;

    localparam logic START_BIT = 1'b0;
    localparam logic STOP_BIT  = 1'b1;

    localparam int unsigned PRESCALE_8  = 8;
    localparam int unsigned PRESCALE_16 = 16;
    localparam int unsigned PRESCALE_32 = 32;

    function automatic logic majority3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

    function automatic logic prescale_legal(input int unsigned p);
        return (p == PRESCALE_8) || (p == PRESCALE_16) || (p == PRESCALE_32);
    endfunction

endpackage

// File: rtl/uart_rx_sampler.sv
// rtl/uart_rx_sampler.sv - per-bit edge counter with 3-sample majority vote
module uart_rx_sampler
    import uart_pkg::*;
#(
    parameter int PRESCALE_W = 6
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  rx_i,
    input  logic                  start_i,
    input  logic                  run_i,
    input  logic [PRESCALE_W-1:0] prescale_i,
    output logic                  sampled_bit_o,
    output logic                  sample_done_o
);

    localparam logic [PRESCALE_W-1:0] ONE = {{(PRESCALE_W-1){1'b0}}, 1'b1};

    logic [PRESCALE_W-1:0] edge_cnt_q, edge_cnt_d;
    logic [PRESCALE_W-1:0] half, last;
    logic                  s0_q, s1_q, bit_q;

    assign half = prescale_i >> 1;
    assign last = prescale_i - ONE;

    // The start-detect cycle is edge 0, so the counter enters the frame at 1.
    always_comb begin
        edge_cnt_d = '0;
        if (start_i) begin
            edge_cnt_d = ONE;
        end else if (run_i) begin
            edge_cnt_d = (edge_cnt_q == last) ? '0 : edge_cnt_q + ONE;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            edge_cnt_q <= '0;
            s0_q       <= 1'b1;
            s1_q       <= 1'b1;
            bit_q      <= 1'b1;
        end else begin
            edge_cnt_q <= edge_cnt_d;
            if (run_i) begin
                if (edge_cnt_q == half - ONE) s0_q <= rx_i;
                if (edge_cnt_q == half)       s1_q <= rx_i;
                if (edge_cnt_q == half + ONE) bit_q <= majority3(s0_q, s1_q, rx_i);
            end
        end
    end

    assign sampled_bit_o = bit_q;
    assign sample_done_o = run_i && (edge_cnt_q == last);

endmodule

// File: rtl/uart_rx.sv
// rtl/uart_rx.sv - UART receiver: deframes RX_IN with parity and stop checks
module uart_rx
    import uart_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int PRESCALE_W = 6
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  RX_IN,
    input  logic [PRESCALE_W-1:0] PRESCALE,
    input  logic                  PAR_EN,
    input  logic                  PAR_TYP,
    output logic [DATA_WIDTH-1:0] P_DATA,
    output logic                  data_valid,
    output logic                  par_err,
    output logic                  stp_err,
    output logic                  busy
);

    localparam int CNT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_WIDTH - 1);

    rx_state_e             state_q, state_d;
    logic [CNT_W-1:0]      bit_cnt_q, bit_cnt_d;
    logic [DATA_WIDTH-1:0] shift_q, shift_d;
    logic [DATA_WIDTH-1:0] p_data_q, p_data_d;
    logic [PRESCALE_W-1:0] prescale_q, prescale_d;
    logic                  par_en_q, par_en_d;
    logic                  par_typ_q, par_typ_d;
    logic                  par_fail_q, par_fail_d;
    logic                  data_valid_q, data_valid_d;
    logic                  par_err_q, par_err_d;
    logic                  stp_err_q, stp_err_d;

    logic start_det, run, sampled_bit, sample_done;

    assign start_det = (state_q == IDLE) && (RX_IN == START_BIT);
    assign run       = (state_q != IDLE);

    uart_rx_sampler #(
        .PRESCALE_W(PRESCALE_W)
    ) u_sampler (
        .clk          (clk),
        .rst          (rst),
        .rx_i         (RX_IN),
        .start_i      (start_det),
        .run_i        (run),
        .prescale_i   (prescale_q),
        .sampled_bit_o(sampled_bit),
        .sample_done_o(sample_done)
    );

    always_comb begin
        state_d      = state_q;
        bit_cnt_d    = bit_cnt_q;
        shift_d      = shift_q;
        p_data_d     = p_data_q;
        prescale_d   = prescale_q;
        par_en_d     = par_en_q;
        par_typ_d    = par_typ_q;
        par_fail_d   = par_fail_q;
        data_valid_d = 1'b0;
        par_err_d    = 1'b0;
        stp_err_d    = 1'b0;

        case (state_q)
            IDLE: begin
                if (start_det) begin
                    state_d    = START;
                    prescale_d = PRESCALE;
                    par_en_d   = PAR_EN;
                    par_typ_d  = PAR_TYP;
                    par_fail_d = 1'b0;
                    bit_cnt_d  = '0;
                end
            end
            START: begin
                if (sample_done) begin
                    state_d = (sampled_bit == START_BIT) ? DATA : IDLE;
                end
            end
            DATA: begin
                if (sample_done) begin
                    shift_d = {sampled_bit, shift_q[DATA_WIDTH-1:1]};
                    if (bit_cnt_q == LAST_BIT) begin
                        bit_cnt_d = '0;
                        state_d   = par_en_q ? PARITY : STOP;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 1'b1;
                    end
                end
            end
            PARITY: begin
                if (sample_done) begin
                    par_fail_d = (sampled_bit != ((^shift_q) ^ par_typ_q));
                    state_d    = STOP;
                end
            end
            STOP: begin
                // A parity failure takes precedence over a bad stop bit.
                if (sample_done) begin
                    state_d = IDLE;
                    if (par_fail_q) begin
                        par_err_d = 1'b1;
                    end else if (sampled_bit != STOP_BIT) begin
                        stp_err_d = 1'b1;
                    end else begin
                        p_data_d     = shift_q;
                        data_valid_d = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            bit_cnt_q    <= '0;
            shift_q      <= '0;
            p_data_q     <= '0;
            prescale_q   <= '0;
            par_en_q     <= 1'b0;
            par_typ_q    <= 1'b0;
            par_fail_q   <= 1'b0;
            data_valid_q <= 1'b0;
            par_err_q    <= 1'b0;
            stp_err_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            bit_cnt_q    <= bit_cnt_d;
            shift_q      <= shift_d;
            p_data_q     <= p_data_d;
            prescale_q   <= prescale_d;
            par_en_q     <= par_en_d;
            par_typ_q    <= par_typ_d;
            par_fail_q   <= par_fail_d;
            data_valid_q <= data_valid_d;
            par_err_q    <= par_err_d;
            stp_err_q    <= stp_err_d;
        end
    end

    assign P_DATA     = p_data_q;
    assign data_valid = data_valid_q;
    assign par_err    = par_err_q;
    assign stp_err    = stp_err_q;
    assign busy       = run;

endmodule

// File: tb/tb_uart_rx.sv
// tb/tb_uart_rx.sv - self-checking bench for uart_rx
module tb_uart_rx;

    localparam logic [2:0] K_VALID = 3'b100;
    localparam logic [2:0] K_PERR  = 3'b010;
    localparam logic [2:0] K_SERR  = 3'b001;

    logic       clk = 1'b0;
    logic       rst;
    logic       rx;
    logic [5:0] prescale;
    logic       par_en, par_typ;
    logic [7:0] p_data;
    logic       dv, pe, se, busy;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    logic [7:0] last_good = 8'h00;

    typedef struct {
        int         cyc;
        logic [2:0] kind;
        logic [7:0] d;
    } ev_t;

    typedef struct {
        int         p;
        bit         pe;
        bit         pt;
        logic [7:0] d;
        bit         bad_par;
        bit         bad_stop;
        bit         b2b;
        logic [2:0] exp_kind;
    } vec_t;

    ev_t exp_q[$];
    ev_t act_q[$];

    uart_rx #(.DATA_WIDTH(8), .PRESCALE_W(6)) dut (
        .clk       (clk),
        .rst       (rst),
        .RX_IN     (rx),
        .PRESCALE  (prescale),
        .PAR_EN    (par_en),
        .PAR_TYP   (par_typ),
        .P_DATA    (p_data),
        .data_valid(dv),
        .par_err   (pe),
        .stp_err   (se),
        .busy      (busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (dv || pe || se) begin
            act_q.push_back('{cyc: cyc, kind: {dv, pe, se}, d: p_data});
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Frame outcome from the UART rules: total ones over data+parity must match the parity type.
    function automatic logic [2:0] model_kind(input bit pen, input bit pt, input logic [7:0] d,
                                              input bit par_bit, input bit stop_bit);
        int ones;
        ones = $countones(d) + int'(par_bit);
        if (pen && ((ones % 2) != int'(pt))) return K_PERR;
        if (!stop_bit) return K_SERR;
        return K_VALID;
    endfunction

    function automatic int pick_prescale();
        int r;
        r = $urandom_range(0, 2);
        return (r == 0) ? 8 : (r == 1) ? 16 : 32;
    endfunction

    task automatic send_frame(input int p, input bit pen, input bit pt, input logic [7:0] d,
                              input bit bad_par, input bit bad_stop, input logic [2:0] exp_kind);
        bit bits[$];
        int start;
        bit par_bit;
        par_bit = bit'(($countones(d) + int'(pt)) % 2) ^ bad_par;
        bits.push_back(1'b0);
        for (int i = 0; i < 8; i++) bits.push_back(d[i]);
        if (pen) bits.push_back(par_bit);
        bits.push_back(!bad_stop);
        prescale = 6'(p);
        par_en   = pen;
        par_typ  = pt;
        start    = cyc;
        exp_q.push_back('{cyc: start + bits.size() * p, kind: exp_kind, d: d});
        if (exp_kind == K_VALID) last_good = d;
        for (int i = 0; i < bits.size(); i++) begin
            rx = bits[i];
            for (int k = 0; k < p; k++) begin
                tick();
                if (i == 0 && k == 0) begin
                    prescale = 6'(pick_prescale());
                    par_en   = 1'($urandom_range(0, 1));
                    par_typ  = 1'($urandom_range(0, 1));
                end
            end
        end
        rx = 1'b1;
    endtask

    task automatic check_events(input string tag);
        ev_t e, a;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            if (act_q.size() == 0) begin
                chk({tag, " missing_event_cycle"}, 32'hFFFF_FFFF, e.cyc);
            end else begin
                a = act_q.pop_front();
                chk({tag, " event_cycle"}, a.cyc, e.cyc);
                chk({tag, " event_kind"}, {29'b0, a.kind}, {29'b0, e.kind});
                if (e.kind == K_VALID) chk({tag, " p_data"}, {24'b0, a.d}, {24'b0, e.d});
            end
        end
        while (act_q.size() > 0) begin
            a = act_q.pop_front();
            chk({tag, " unexpected_event_cycle"}, a.cyc, 32'hFFFF_FFFF);
        end
        chk({tag, " p_data_hold"}, {24'b0, p_data}, {24'b0, last_good});
        chk({tag, " busy_idle"}, {31'b0, busy}, 32'd0);
    endtask

    vec_t vecs[7];

    initial begin
        vecs[0] = '{8,  1, 0, 8'hA5, 0, 0, 0, K_VALID};
        vecs[1] = '{16, 0, 0, 8'h3C, 0, 0, 1, K_VALID};
        vecs[2] = '{16, 0, 0, 8'hFF, 0, 0, 0, K_VALID};
        vecs[3] = '{8,  1, 1, 8'h01, 1, 0, 0, K_PERR};
        vecs[4] = '{32, 0, 0, 8'h55, 0, 1, 0, K_SERR};
        vecs[5] = '{8,  1, 1, 8'h3E, 1, 1, 0, K_PERR};
        vecs[6] = '{16, 1, 0, 8'h00, 0, 0, 0, K_VALID};

        rst = 1'b1; rx = 1'b1; prescale = 6'd8; par_en = 1'b0; par_typ = 1'b0;
        repeat (3) tick();
        chk("reset busy", {31'b0, busy}, 32'd0);
        chk("reset outputs", {21'b0, p_data, dv, pe, se}, 32'd0);
        rst = 1'b0;
        repeat (4) tick();

        for (int i = 0; i < 7; i++) begin
            send_frame(vecs[i].p, vecs[i].pe, vecs[i].pt, vecs[i].d,
                       vecs[i].bad_par, vecs[i].bad_stop, vecs[i].exp_kind);
            if (!vecs[i].b2b) begin
                repeat (3) tick();
                check_events($sformatf("vec%0d", i));
            end
        end

        // Two-clock glitch: START rejects it at the end of the first bit period.
        prescale = 6'd8; par_en = 1'b0;
        rx = 1'b0;
        repeat (2) tick();
        rx = 1'b1;
        repeat (5) tick();
        chk("glitch busy_at_7", {31'b0, busy}, 32'd1);
        tick();
        chk("glitch busy_at_8", {31'b0, busy}, 32'd0);
        repeat (3) tick();
        check_events("glitch");
        send_frame(8, 0, 0, 8'h12, 0, 0, K_VALID);
        repeat (3) tick();
        check_events("after_glitch");

        // Reset in the middle of the data bits discards the frame.
        prescale = 6'd8; par_en = 1'b0;
        rx = 1'b0;
        repeat (8) tick();
        for (int i = 0; i < 3; i++) begin
            rx = 1'(8'h5A >> i);
            repeat (8) tick();
        end
        rst = 1'b1;
        #1;
        chk("midreset busy", {31'b0, busy}, 32'd0);
        chk("midreset outputs", {21'b0, p_data, dv, pe, se}, 32'd0);
        repeat (2) tick();
        rst = 1'b0; rx = 1'b1; last_good = 8'h00;
        repeat (5) tick();
        check_events("midreset");
        send_frame(8, 0, 0, 8'h81, 0, 0, K_VALID);
        repeat (3) tick();
        check_events("after_reset");

        for (int n = 0; n < 24; n++) begin
            int         p;
            bit         pen, pt, bp, bs, par_bit;
            logic [7:0] d;
            p   = pick_prescale();
            pen = 1'($urandom_range(0, 1));
            pt  = 1'($urandom_range(0, 1));
            d   = 8'($urandom);
            bp  = ($urandom_range(0, 3) == 0);
            bs  = ($urandom_range(0, 3) == 0);
            par_bit = bit'(($countones(d) + int'(pt)) % 2) ^ bp;
            send_frame(p, pen, pt, d, bp, bs, model_kind(pen, pt, d, par_bit, !bs));
            repeat ($urandom_range(0, 3)) tick();
        end
        repeat (3) tick();
        check_events("random");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
- UART receiver that pairs with the existing UART transmitter; same frame format.
- Frame: 1 start bit (0), DATA_WIDTH data bits LSB first, optional parity bit, 1 stop bit (1).
- Runs on a single oversampling clock (PRESCALE clocks per bit) and deframes RX_IN into a parallel word with parity and stop-bit checks.
- Sits in the UART RX path, feeding the RX data synchronizer / system controller.

Parameters:
- DATA_WIDTH, 8, number of data bits per frame.
- PRESCALE_W, 6, width of the PRESCALE input.

Ports:
- clk  input  1  oversampling clock (PRESCALE x bit rate).
- rst  input  1  asynchronous reset, active-high.
- RX_IN  input  1  serial line; idles high; already synchronized upstream.
- PRESCALE  input  PRESCALE_W  clocks per bit; legal values 8, 16, 32.
- PAR_EN  input  1  1 = parity bit present in the frame.
- PAR_TYP  input  1  0 = even parity, 1 = odd parity.
- P_DATA  output  DATA_WIDTH  received word; held until the next good frame.
- data_valid  output  1  one-clk pulse when P_DATA is updated.
- par_err  output  1  one-clk pulse, parity mismatch.
- stp_err  output  1  one-clk pulse, stop bit sampled 0.
- busy  output  1  high while not IDLE.

Behaviour:
- Reset (async, active-high): state = IDLE, all counters 0, P_DATA = 0, data_valid/par_err/stp_err/busy = 0. This applies at any time, including mid-frame; the partial frame is discarded and no pulse is produced.
- PRESCALE, PAR_EN and PAR_TYP are latched when a start edge is detected. Changes mid-frame have no effect on the current frame. Illegal PRESCALE values give undefined results.
- Counters:
  - edge_cnt runs 0..PRESCALE-1 within each bit, wraps to 0, and increments bit_cnt.
  - bit_cnt counts data bits 0..DATA_WIDTH-1.
- Sampling: bit value is the majority of 3 samples at edge_cnt = P/2-1, P/2, P/2+1. The result is registered and valid from edge_cnt = P/2+2.
- FSM states: IDLE, START, DATA, PARITY, STOP.
  - IDLE: RX_IN = 0 -> START, with edge_cnt = 1 on the next clk (the detection cycle counts as edge 0).
  - START: at edge_cnt = P-1, sampled bit 0 -> DATA. Sampled bit 1 -> IDLE (glitch), with no error pulse.
  - DATA: shift the sampled bit into the MSB of the shift register at each bit end (LSB-first frame). After bit DATA_WIDTH-1 ends, go to PARITY if PAR_EN = 1, else to STOP.
  - PARITY: compute expected = ^data XOR PAR_TYP. Mismatch sets an internal par_fail flag. At bit end -> STOP.
  - STOP: at edge_cnt = P-1, return to IDLE and produce the frame result, registered, visible the next clk:
    - par_fail -> par_err = 1, no data_valid.
    - Else stop sample 0 -> stp_err = 1, no data_valid.
    - Else P_DATA = shift register and data_valid = 1.
- Only one of data_valid, par_err or stp_err is pulsed per frame. When par_fail and a bad stop occur together, only par_err is reported.
- Back-to-back frames: the FSM is in IDLE the clk after the stop bit ends. A start bit beginning on that clk is detected with no lost cycles.
- busy = 1 whenever state != IDLE.
- Latency: data_valid rises N*P clks after the first low sample of RX_IN, where N = bits in the frame (10 without parity, 11 with parity).

Decomposition:
- Package uart_pkg holds:
  - The state enum (IDLE, START, DATA, PARITY, STOP).
  - Constants START_BIT = 0 and STOP_BIT = 1.
  - The legal prescale constants 8, 16, 32.
- Sub-module uart_rx_sampler contains edge_cnt, the 3-sample majority vote and the sample_done strobe.
- The FSM, shift register, parity check and output registers stay in uart_rx.

Test Plan:
- PRESCALE = 8, PAR_EN = 1, PAR_TYP = 0, frame 0xA5 with even parity bit 0 -> data_valid pulses for exactly 1 clk at cycle 88 after the first low sample. P_DATA = 0xA5; par_err = stp_err = 0.
- PRESCALE = 16, PAR_EN = 0, frames 0x3C and 0xFF sent back-to-back with no idle -> two data_valid pulses 160 clks apart; P_DATA = 0x3C, then 0xFF.
- PRESCALE = 8, PAR_EN = 1, PAR_TYP = 1, data 0x01 sent with wrong parity bit 1 -> par_err pulses at cycle 88; no data_valid; P_DATA keeps its previous value.
- PRESCALE = 32, PAR_EN = 0, 0x55 with the stop bit forced 0 -> stp_err pulses at cycle 320; no data_valid; the FSM returns to IDLE.
- 2-clk low glitch on an idle line at PRESCALE = 8 -> FSM returns to IDLE after 8 clks; no pulses.
- A clean 0x12 frame follows the glitch -> received correctly.
- rst asserted mid-DATA, then released, then a clean 0x81 frame -> outputs 0 during reset; no pulse for the aborted frame; 0x81 is received with data_valid.
